uart_rx_buf: RTL and testbench
==============================

# uart_rx_buf

UART receive front end: 16x-oversampled serial receiver plus a small show-ahead byte FIFO. It sits directly upstream of the byte-consumer stage that drives the hex displays. It presents `r_data`/`rx_empty` and pops one byte per cycle in which the consumer asserts `rd_uart`. Framing and overrun faults are reported as single-cycle pulses.

## Interface
- `DVSR`, 54 — clock cycles per oversampling tick (baud × 16 = f_clk / DVSR); legal ≥ 2
- `DBIT`, 8 — data bits per frame
- `SB_TICK`, 16 — ticks spent in the stop bit
- `FIFO_AW`, 2 — FIFO address width; depth = 2**FIFO_AW
- `clk`  in  1  system clock; all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `rx`  in  1  serial line, idle high, asynchronous to `clk`
- `rd_uart`  in  1  pop request; ignored while `rx_empty`=1
- `r_data`  out  8  FIFO head byte, valid while `rx_empty`=0
- `rx_empty`  out  1  FIFO holds no bytes
- `rx_full`  out  1  FIFO holds 2**FIFO_AW bytes
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low
- `overrun`  out  1  one-cycle pulse: completed byte dropped because FIFO full
- `parity_err`  out  1  one-cycle pulse: parity mismatch (tied 0 without macro)

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s`), which resets to 1.
- Tick generator: free-running counter 0..DVSR-1; `tick` is high for one cycle when the counter equals DVSR-1.
- FSM states:
  - IDLE: on `rx_s`=0, go to START and clear the tick count `s`.
  - START: on ticks, `s` increments. At `s`=7, if `rx_s`=0 go to DATA (clear `s`, bit count `n`=0). Otherwise return to IDLE (glitch reject).
  - DATA: at `s`=15, sample `rx_s` into the shift register MSB and shift right (LSB first), then increment `n`. After DBIT bits go to PARITY (macro) or STOP.
  - PARITY (macro only): at `s`=15, sample the parity bit, then go to STOP.
  - STOP: at `s`=SB_TICK-1, finish the frame and return to IDLE.
    - `rx_s`=1 and no parity fault: issue `push`.
    - `rx_s`=0: pulse `frame_err`, discard the byte.
    - Parity mismatch: pulse `parity_err`, discard the byte.
- FIFO: circular buffer with FIFO_AW-bit read/write pointers. `r_data` = mem[rptr] (show-ahead).
  - `pop` = `rd_uart` & ~`rx_empty`.
  - push & ~full: write and advance `wptr`.
  - push & full & ~pop: drop the byte and pulse `overrun`.
  - push & pop while full: both succeed, no overrun.
  - push & pop while empty: only the push takes effect (pop is gated).
  - Flags are registered and updated from the pointer state after push/pop. Pointers wrap modulo depth.
- Reset: FSM returns to IDLE, counters and pointers go to 0, storage clears to 0. Outputs: `r_data`=0x00, `rx_empty`=1, `rx_full`=0, all error pulses 0. Reset mid-frame abandons the frame; no partial push.

## Timing
- `rx` falling edge to FSM START: 2–3 clk (synchronizer + 1).
- Data bits are sampled near mid-bit (start detected at tick 7, then every 16 ticks).
- `push` is issued in the cycle of the last stop tick. `rx_empty` falls and `r_data` is valid on the next clock edge.
- Pop: `r_data` advances and `rx_empty`/`rx_full` update on the clock edge that samples `rd_uart`=1.
- Back-to-back frames: the next start bit is accepted the cycle after STOP → IDLE. With SB_TICK=16 there is no lost frame at nominal baud.
- Error pulses are exactly 1 `clk` wide and coincide with the cycle that would have pushed.

## Configuration
- `UART_RX_PARITY_EN` defined: adds the PARITY state, so frames carry one even-parity bit after the data bits. A mismatch discards the byte and pulses `parity_err`.
- Undefined: no PARITY state, frames are 8N1, and `parity_err` is constant 0.

## Test plan
- **Reset:** hold `reset_n`=0 → `rx_empty`=1, `rx_full`=0, `r_data`=0x00, all errors 0. Release with `rx`=1 for 1000 clk → no change.
- **Single frame:** DVSR=4, send 0xA5 8N1 (64 clk/bit) → `rx_empty` falls one cycle after the stop sample, `r_data`=0xA5. Pulse `rd_uart` 1 clk → `rx_empty`=1.
- **Glitch reject:** drive `rx` low for 20 clk (less than 8 ticks × 4) → FSM back in IDLE, nothing pushed.
- **Overrun and wrap:** FIFO_AW=2, send 0x01..0x05 with no reads → `rx_full`=1 after 0x04, `overrun` pulses on 0x05. Then read 4× → 0x01, 0x02, 0x03, 0x04, `rx_empty`=1. Send 0x06 → pointers wrap and `r_data`=0x06.
- **Framing error:** send 0x3C with the stop bit held low → `frame_err` pulses 1 clk, `rx_empty` stays 1. A following good 0x55 is received correctly.
- **Parity (UART_RX_PARITY_EN):** send 0x07 with parity 1 → stored. Send 0x07 with parity 0 → `parity_err` pulse, no push.

Source files
------------

// File: rtl/uart_rx_buf.sv
// uart_rx_buf: 16x-oversampled UART receiver feeding a show-ahead byte FIFO.
// Define UART_RX_PARITY_EN to expect one even-parity bit after the data bits (default: 8N1).
module uart_rx_buf #(
   parameter int DVSR    = 54,
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int FIFO_AW = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx,
   input  logic       rd_uart,
   output logic [7:0] r_data,
   output logic       rx_empty,
   output logic       rx_full,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err
);
   localparam int DEPTH = 2**FIFO_AW;
   localparam int TW    = (DVSR > 1) ? $clog2(DVSR) : 1;
   localparam int SW    = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam int NW    = $clog2(DBIT + 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   // ---------------- input synchronizer ----------------
   logic r_rx_meta, r_rx_s;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         // NOTE: non-blocking so each flop takes its pre-edge input; blocking would merge the two stages.
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   // ---------------- oversampling tick ----------------
   logic [TW-1:0] r_tcnt;
   logic          w_tick;

   assign w_tick = (r_tcnt == TW'(DVSR - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    r_tcnt <= '0;
      else if (w_tick) r_tcnt <= '0;
      else             r_tcnt <= r_tcnt + TW'(1);
   end

   // ---------------- receive FSM ----------------
   state_t        r_state, w_state_nxt;
   logic [SW-1:0] r_s, w_s_nxt;
   logic [NW-1:0] r_n, w_n_nxt;
   logic [7:0]    r_b, w_b_nxt;
   logic          w_push, w_frame_err;
`ifdef UART_RX_PARITY_EN
   logic          r_par, w_par_nxt, w_par_err;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_s     <= '0;
         r_n     <= '0;
         r_b     <= '0;
`ifdef UART_RX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_s     <= w_s_nxt;
         r_n     <= w_n_nxt;
         r_b     <= w_b_nxt;
`ifdef UART_RX_PARITY_EN
         r_par   <= w_par_nxt;
`endif
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (which would infer a latch).
      w_state_nxt = r_state;
      w_s_nxt     = r_s;
      w_n_nxt     = r_n;
      w_b_nxt     = r_b;
      w_push      = 1'b0;
      w_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_nxt   = r_par;
      w_par_err   = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (!r_rx_s) begin
               w_state_nxt = START;
               w_s_nxt     = '0;
            end
         end
         START: begin
            if (w_tick) begin
               if (r_s == SW'(7)) begin
                  // Start bit must still be low at mid-bit, otherwise it was a glitch
                  if (!r_rx_s) begin
                     w_state_nxt = DATA;
                     w_s_nxt     = '0;
                     w_n_nxt     = '0;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_s_nxt = r_s + SW'(1);
               end
            end
         end
         DATA: begin
            if (w_tick) begin
               if (r_s == SW'(15)) begin
                  w_s_nxt = '0;
                  w_b_nxt = {r_rx_s, r_b[7:1]};
                  if (r_n == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                     w_state_nxt = PARITY;
`else
                     w_state_nxt = STOP;
`endif
                  end else begin
                     w_n_nxt = r_n + NW'(1);
                  end
               end else begin
                  w_s_nxt = r_s + SW'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (w_tick) begin
               if (r_s == SW'(15)) begin
                  w_par_nxt   = r_rx_s;
                  w_s_nxt     = '0;
                  w_state_nxt = STOP;
               end else begin
                  w_s_nxt = r_s + SW'(1);
               end
            end
         end
`endif
         STOP: begin
            if (w_tick) begin
               if (r_s == SW'(SB_TICK - 1)) begin
                  w_state_nxt = IDLE;
                  w_frame_err = ~r_rx_s;
`ifdef UART_RX_PARITY_EN
                  // Even parity: data plus parity bit must hold an even count of ones
                  w_par_err   = r_par ^ (^r_b);
                  w_push      = r_rx_s & ~w_par_err;
`else
                  w_push      = r_rx_s;
`endif
               end else begin
                  w_s_nxt = r_s + SW'(1);
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign frame_err = w_frame_err;
`ifdef UART_RX_PARITY_EN
   assign parity_err = w_par_err;
`else
   assign parity_err = 1'b0;
`endif

   // ---------------- show-ahead FIFO ----------------
   logic [7:0]         r_mem [DEPTH];
   logic [FIFO_AW-1:0] r_wptr, r_rptr, w_wptr_inc, w_rptr_inc;
   logic               r_empty, r_full;
   logic               w_pop, w_wr;

   assign w_pop      = rd_uart & ~r_empty;
   // A full FIFO still accepts a push when the same cycle frees a slot
   assign w_wr       = w_push & (~r_full | w_pop);
   assign overrun    = w_push & r_full & ~w_pop;
   assign w_wptr_inc = r_wptr + FIFO_AW'(1);
   assign w_rptr_inc = r_rptr + FIFO_AW'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: storage is reset on purpose so the head byte reads 0x00 after reset, not stale data.
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_wr) begin
         r_mem[r_wptr] <= r_b;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_empty <= 1'b1;
         r_full  <= 1'b0;
      end else begin
         case ({w_wr, w_pop})
            2'b10: begin
               r_wptr  <= w_wptr_inc;
               r_empty <= 1'b0;
               r_full  <= (w_wptr_inc == r_rptr);
            end
            2'b01: begin
               r_rptr  <= w_rptr_inc;
               r_full  <= 1'b0;
               r_empty <= (w_rptr_inc == r_wptr);
            end
            2'b11: begin
               r_wptr <= w_wptr_inc;
               r_rptr <= w_rptr_inc;
            end
            default: ;
         endcase
      end
   end

   assign r_data   = r_mem[r_rptr];
   assign rx_empty = r_empty;
   assign rx_full  = r_full;

endmodule

// File: tb/tb_uart_rx_buf.sv
// Self-checking bench for uart_rx_buf: table-driven frames, corner sequences and
// random frames scored against a queue-based FIFO model. Honours UART_RX_PARITY_EN.
module tb_uart_rx_buf;
   localparam int DVSR    = 4;
   localparam int FIFO_AW = 2;
   localparam int DEPTH   = 4;
   localparam int BIT_CLK = 16 * DVSR;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       rx = 1'b1;
   logic       rd_uart = 1'b0;
   logic [7:0] r_data;
   logic       rx_empty, rx_full, frame_err, overrun, parity_err;

   uart_rx_buf #(.DVSR(DVSR), .DBIT(8), .SB_TICK(16), .FIFO_AW(FIFO_AW)) dut (
      .clk(clk), .reset_n(reset_n), .rx(rx), .rd_uart(rd_uart),
      .r_data(r_data), .rx_empty(rx_empty), .rx_full(rx_full),
      .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Cycles each pulse output spends high; a correct pulse contributes exactly one.
   int fe_hi = 0, ov_hi = 0, pe_hi = 0;
   int exp_fe = 0, exp_ov = 0, exp_pe = 0;
   logic [7:0] q[$];

   always @(negedge clk) begin
      if (frame_err  !== 1'b0) fe_hi++;
      if (overrun    !== 1'b0) ov_hi++;
      if (parity_err !== 1'b0) pe_hi++;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: a well-framed byte lands in the FIFO if there is room, else counts as overrun.
   task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit par_flip);
      bit par_ok;
      par_ok = !(PAR_EN && par_flip);
      if (!stop_ok) exp_fe++;
      if (!par_ok)  exp_pe++;
      if (stop_ok && par_ok) begin
         if (q.size() < DEPTH) q.push_back(d);
         else                  exp_ov++;
      end
   endtask

   task automatic send_bit(input logic b, input int len);
      rx = b;
      repeat (len) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_flip);
      send_bit(1'b0, BIT_CLK);
      for (int i = 0; i < 8; i++) send_bit(d[i], BIT_CLK);
      if (PAR_EN) send_bit((^d) ^ par_flip, BIT_CLK);
      // A bad stop bit is released early so the receiver's re-armed start detector rejects it.
      if (stop_ok) send_bit(1'b1, BIT_CLK);
      else begin
         send_bit(1'b0, BIT_CLK * 3 / 4);
         send_bit(1'b1, BIT_CLK / 4);
      end
      rx = 1'b1;
      model_frame(d, stop_ok, par_flip);
   endtask

   task automatic check_state(input string tag);
      check({tag, "_empty"}, rx_empty, q.size() == 0);
      check({tag, "_full"},  rx_full,  q.size() == DEPTH);
      if (q.size() > 0) check({tag, "_head"}, r_data, q[0]);
      check({tag, "_frame_err_count"},  fe_hi, exp_fe);
      check({tag, "_overrun_count"},    ov_hi, exp_ov);
      check({tag, "_parity_err_count"}, pe_hi, exp_pe);
   endtask

   task automatic do_read();
      if (q.size() > 0) begin
         check("pop_head", r_data, q[0]);
         void'(q.pop_front());
      end
      rd_uart = 1'b1;
      @(negedge clk);
      rd_uart = 1'b0;
      check("pop_empty", rx_empty, q.size() == 0);
      check("pop_full",  rx_full,  q.size() == DEPTH);
   endtask

   typedef struct {
      logic [7:0] data;
      bit         stop_ok;
      bit         par_flip;
      int         reads;
      bit         exp_empty;
      bit         exp_full;
      logic [7:0] exp_head;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int t;
      // Hand-derived expectations: state right after each frame, before its reads.
      vecs.push_back('{8'hA5, 1'b1, 1'b0, 1, 1'b0, 1'b0, 8'hA5});
      vecs.push_back('{8'h01, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'h01});
      vecs.push_back('{8'h02, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'h01});
      vecs.push_back('{8'h03, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'h01});
      vecs.push_back('{8'h04, 1'b1, 1'b0, 0, 1'b0, 1'b1, 8'h01});
      vecs.push_back('{8'h05, 1'b1, 1'b0, 4, 1'b0, 1'b1, 8'h01});
      vecs.push_back('{8'h06, 1'b1, 1'b0, 1, 1'b0, 1'b0, 8'h06});
      vecs.push_back('{8'h3C, 1'b0, 1'b0, 0, 1'b1, 1'b0, 8'h00});
      vecs.push_back('{8'h55, 1'b1, 1'b0, 1, 1'b0, 1'b0, 8'h55});
`ifdef UART_RX_PARITY_EN
      vecs.push_back('{8'h07, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'h07});
      vecs.push_back('{8'h07, 1'b1, 1'b1, 1, 1'b0, 1'b0, 8'h07});
`endif

      // Reset state, then idle line after release
      repeat (3) @(negedge clk);
      check("rst_empty", rx_empty, 1'b1);
      check("rst_full",  rx_full,  1'b0);
      check("rst_data",  r_data,   8'h00);
      check("rst_errs",  {frame_err, overrun, parity_err}, 3'b000);
      reset_n = 1'b1;
      repeat (1000) @(negedge clk);
      check_state("idle");
      check("idle_data", r_data, 8'h00);

      // Glitch shorter than half a bit must not start a frame
      send_bit(1'b0, 20);
      send_bit(1'b1, 200);
      check_state("glitch");

      for (int i = 0; i < vecs.size(); i++) begin
         send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].par_flip);
         repeat (BIT_CLK) @(negedge clk);
         check($sformatf("vec%0d_empty", i), rx_empty, vecs[i].exp_empty);
         check($sformatf("vec%0d_full", i),  rx_full,  vecs[i].exp_full);
         if (!vecs[i].exp_empty) check($sformatf("vec%0d_head", i), r_data, vecs[i].exp_head);
         check_state($sformatf("vec%0d", i));
         for (int r = 0; r < vecs[i].reads; r++) do_read();
      end

      // Push latency: rx_empty falls on the edge ending the mid-stop sample cycle
      t = 0;
      fork
         send_frame(8'hC3, 1'b1, 1'b0);
         begin
            while (rx_empty === 1'b1 && t < 800) begin
               @(negedge clk);
               t++;
            end
         end
      join
      check("latency_in_window", (t >= 606 && t <= 614), 1'b1);
      check_state("latency");
      do_read();

      // Pop while empty is ignored
      rd_uart = 1'b1;
      repeat (2) @(negedge clk);
      rd_uart = 1'b0;
      check_state("pop_empty_ignored");

      // Randomised frames, stop/parity faults and reads against the model
      for (int i = 0; i < 16; i++) begin
         send_frame(8'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0));
         repeat (BIT_CLK) @(negedge clk);
         check_state($sformatf("rand%0d", i));
         for (int r = $urandom_range(0, 3); r > 0; r--) do_read();
      end

      // Reset mid-frame with data stored: storage clears and the partial frame is lost
      send_frame(8'h81, 1'b1, 1'b0);
      repeat (BIT_CLK) @(negedge clk);
      send_bit(1'b0, BIT_CLK);
      send_bit(1'b1, BIT_CLK);
      send_bit(1'b0, BIT_CLK / 2);
      reset_n = 1'b0;
      @(negedge clk);
      check("midrst_data",  r_data,   8'h00);
      check("midrst_empty", rx_empty, 1'b1);
      check("midrst_full",  rx_full,  1'b0);
      q.delete();
      rx = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (800) @(negedge clk);
      check_state("after_midrst");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
